// File: rtl/pir_pkg.sv
// Shared types and seven-segment codes for the
// three-zone PIR motion alarm.
package pir_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    ALARM    = 2'd2
  } state_t;

  // Segment order gfedcba, active-high.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;

  function automatic logic [6:0] seg_digit(
    input state_t     st,
    input logic       lat,
    input logic [6:0] code
  );
    logic [6:0] d;
    d = SEG_DASH;
    if (st == DISARMED) d = SEG_BLANK;
    else if (lat)       d = code;
    return d;
  endfunction

endpackage

// File: rtl/pir_zone_debounce.sv
// One PIR zone: counts consecutive motion samples
// and sets a sticky latch once the run is long enough.
module pir_zone_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic [6:0] sample,
  input  logic [6:0] threshold,
  input  logic       enable,
  input  logic       clear,
  output logic       latch,
  output logic       trip
);

  localparam logic [3:0] LIMIT = 4'(DEBOUNCE);

  logic [3:0] cnt;
  logic       motion;

  assign motion = (sample >= threshold);

  // Asserted on the edge whose sample completes the run.
  assign trip = enable & motion & (cnt >= LIMIT - 4'd1);

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt   <= '0;
      latch <= 1'b0;
    end else if (enable) begin
      if (!motion)
        cnt <= '0;
      else if (cnt < LIMIT)
        cnt <= cnt + 4'd1;
      if (trip)
        latch <= 1'b1;
    end
  end

endmodule

// File: rtl/pir_motion_alarm.sv
// Three-zone PIR alarm: FSM, zone latches,
// pulsed buzzer and seven-segment zone display.
module pir_motion_alarm
  import pir_pkg::*;
#(
  parameter logic [6:0] THRESHOLD = 7'd64,
  parameter int         DEBOUNCE  = 4,
  parameter int         BUZZ_HALF = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        turn,
  input  logic        stop_alarm,
  input  logic [6:0]  pir_sensor_1,
  input  logic [6:0]  pir_sensor_2,
  input  logic [6:0]  pir_sensor_3,
  output logic [2:0]  LED,
  output logic        buzzer,
  output logic [20:0] display_data
);

  localparam logic [7:0] HALF = 8'(BUZZ_HALF);

  state_t     state, state_next;
  logic [2:0] latch, trip, latch_next;
  logic [7:0] bz_cnt;
  logic       enable, clear;

  assign enable = (state != DISARMED);
  assign clear  = reset | ~turn |
                  ((state == ALARM) & stop_alarm);

  pir_zone_debounce #(.DEBOUNCE(DEBOUNCE)) u_z1 (
    .clk(clk), .sample(pir_sensor_1),
    .threshold(THRESHOLD), .enable(enable),
    .clear(clear), .latch(latch[0]), .trip(trip[0])
  );
  pir_zone_debounce #(.DEBOUNCE(DEBOUNCE)) u_z2 (
    .clk(clk), .sample(pir_sensor_2),
    .threshold(THRESHOLD), .enable(enable),
    .clear(clear), .latch(latch[1]), .trip(trip[1])
  );
  pir_zone_debounce #(.DEBOUNCE(DEBOUNCE)) u_z3 (
    .clk(clk), .sample(pir_sensor_3),
    .threshold(THRESHOLD), .enable(enable),
    .clear(clear), .latch(latch[2]), .trip(trip[2])
  );

  assign latch_next = clear ? 3'b000 : (latch | trip);
  assign LED        = latch;

  always_comb begin
    state_next = state;
    if (reset || !turn) begin
      state_next = DISARMED;
    end else begin
      case (state)
        DISARMED: state_next = ARMED;
        ARMED:    if (|trip) state_next = ALARM;
        ALARM:    if (stop_alarm) state_next = ARMED;
        default:  state_next = DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= DISARMED;
    else       state <= state_next;
  end

  // bz_cnt counts cycles already shown in the current tone phase.
  always_ff @(posedge clk) begin
    if (reset || state_next != ALARM) begin
      buzzer <= 1'b0;
      bz_cnt <= '0;
    end else if (state != ALARM) begin
      buzzer <= 1'b1;
      bz_cnt <= 8'd1;
    end else if (bz_cnt == HALF) begin
      buzzer <= ~buzzer;
      bz_cnt <= 8'd1;
    end else begin
      bz_cnt <= bz_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      display_data <= '0;
    end else begin
      display_data <= {
        seg_digit(state_next, latch_next[2], SEG_3),
        seg_digit(state_next, latch_next[1], SEG_2),
        seg_digit(state_next, latch_next[0], SEG_1)
      };
    end
  end

endmodule

// File: tb/tb_pir_motion_alarm.sv
// Directed plus randomized bench for pir_motion_alarm
// against a cycle-level behavioural model.
module tb_pir_motion_alarm;

  localparam int DB   = 4;
  localparam int HALF = 8;
  localparam int THR  = 64;

  logic        clk = 1'b0;
  logic        reset, turn, stop_alarm;
  logic [6:0]  s1, s2, s3;
  logic [2:0]  LED;
  logic        buzzer;
  logic [20:0] display_data;

  int vectors = 0;
  int miscompares = 0;

  // model: mode 0 off, 1 watching, 2 alarm
  int mode = 0;
  int age = 0;
  int run [3];
  bit lat [3];
  bit hot [3];

  pir_motion_alarm dut (
    .clk(clk), .reset(reset), .turn(turn),
    .stop_alarm(stop_alarm),
    .pir_sensor_1(s1), .pir_sensor_2(s2),
    .pir_sensor_3(s3), .LED(LED), .buzzer(buzzer),
    .display_data(display_data)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit(int z);
    logic [6:0] code;
    case (z)
      0: code = 7'b0000110;
      1: code = 7'b1011011;
      default: code = 7'b1001111;
    endcase
    if (mode == 0) return 7'b0000000;
    if (lat[z])    return code;
    return 7'b1000000;
  endfunction

  task automatic model_edge();
    int smp [3];
    bit any;
    smp[0] = int'(s1); smp[1] = int'(s2); smp[2] = int'(s3);
    if (reset || !turn) begin
      mode = 0; age = 0;
      for (int z = 0; z < 3; z++) begin
        run[z] = 0; lat[z] = 0;
      end
    end else if (mode == 0) begin
      mode = 1;
    end else if (mode == 2 && stop_alarm) begin
      mode = 1; age = 0;
      for (int z = 0; z < 3; z++) begin
        run[z] = 0; lat[z] = 0;
      end
    end else begin
      any = 0;
      for (int z = 0; z < 3; z++) begin
        if (smp[z] >= THR) run[z] = (run[z] < DB) ? run[z] + 1 : DB;
        else               run[z] = 0;
        if (run[z] == DB) lat[z] = 1;
        any |= lat[z];
      end
      if (mode == 1 && any) begin
        mode = 2; age = 0;
      end else if (mode == 2) begin
        age++;
      end
    end
  endtask

  task automatic step();
    logic [2:0]  e_led;
    logic        e_bz;
    logic [20:0] e_disp;
    @(posedge clk);
    model_edge();
    #1;
    e_led  = {lat[2], lat[1], lat[0]};
    e_bz   = (mode == 2) && (((age / HALF) % 2) == 0);
    e_disp = {digit(2), digit(1), digit(0)};
    vectors++;
    assert (LED === e_led) else begin
      miscompares++;
      $error("FAIL led: observed %b expected %b", LED, e_led);
    end
    vectors++;
    assert (buzzer === e_bz) else begin
      miscompares++;
      $error("FAIL buzzer: observed %b expected %b", buzzer, e_bz);
    end
    vectors++;
    assert (display_data === e_disp) else begin
      miscompares++;
      $error("FAIL display: observed %h expected %h",
             display_data, e_disp);
    end
  endtask

  task automatic drive(input logic t, input logic st,
                       input int a, input int b, input int c);
    turn = t; stop_alarm = st;
    s1 = 7'(a); s2 = 7'(b); s3 = 7'(c);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int sq [8];
    sq = '{70, 70, 70, 10, 70, 70, 70, 70};
    reset = 1'b1;
    drive(0, 0, 100, 100, 100);
    steps(2);
    reset = 1'b0;
    steps(5);

    // arm, zone 2 trips, full buzzer cycle
    drive(1, 0, 0, 80, 0);
    steps(5);
    drive(1, 0, 0, 0, 0);
    steps(20);
    drive(1, 1, 0, 0, 0);
    steps(1);

    // dip inside the run restarts debounce
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, sq[i], 0, 0);
      step();
    end
    drive(1, 0, 0, 0, 80);
    steps(4);
    drive(1, 1, 0, 0, 0);
    steps(1);

    // threshold boundary
    drive(1, 0, 64, 63, 0);
    steps(6);
    drive(1, 1, 0, 63, 0);
    steps(1);
    drive(1, 0, 0, 63, 0);
    steps(6);

    // disarm with stop mid-alarm, then re-arm
    drive(1, 0, 90, 90, 90);
    steps(6);
    drive(0, 1, 90, 90, 90);
    steps(1);
    drive(1, 0, 90, 90, 90);
    steps(7);
    drive(1, 1, 90, 0, 0);
    steps(2);
    drive(1, 0, 90, 0, 0);
    steps(6);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int smp [3];
      reset = ($urandom_range(0, 299) == 0);
      turn = ($urandom_range(0, 49) != 0);
      stop_alarm = ($urandom_range(0, 15) == 0);
      for (int z = 0; z < 3; z++) begin
        if ($urandom_range(0, 7) == 0) hot[z] = ~hot[z];
        if ($urandom_range(0, 9) == 0)
          smp[z] = 63 + int'($urandom_range(0, 1));
        else if (hot[z])
          smp[z] = int'($urandom_range(64, 127));
        else
          smp[z] = int'($urandom_range(0, 63));
      end
      s1 = 7'(smp[0]); s2 = 7'(smp[1]); s3 = 7'(smp[2]);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
